// File: rtl/mul_sweep_ctrl.sv
// Exhaustive operand sweep and error-statistics engine for a combinational WxW multiplier.
// Optional build macro MUL_SWEEP_SUM_EN adds the sum-of-absolute-error accumulator.
module mul_sweep_ctrl #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_r,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_cnt,
    output logic [2*W-1:0]   max_err,
    output logic [W-1:0]     worst_a,
    output logic [W-1:0]     worst_b,
    output logic [4*W-1:0]   sum_abs_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [W-1:0]   ONE_OP  = 1;
    localparam logic [2*W:0]   ONE_CNT = 1;

    state_t           state;
    logic [2*W-1:0]   exact;
    logic [2*W-1:0]   diff;
    logic             last_pair;

    // Magnitude of the signed (2W+1)-bit difference; it always fits in 2W bits.
    function automatic logic [2*W-1:0] abs_diff(input logic [2*W-1:0] r,
                                                input logic [2*W-1:0] e);
        logic signed [2*W:0] d;
        logic signed [2*W:0] mag;
        d   = $signed({1'b0, r}) - $signed({1'b0, e});
        mag = (d < 0) ? -d : d;
        return (2*W)'(mag);
    endfunction

    assign exact     = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    assign diff      = abs_diff(mul_r, exact);
    assign last_pair = (mul_a == {W{1'b1}}) && (mul_b == {W{1'b1}});

`ifndef MUL_SWEEP_SUM_EN
    assign sum_abs_err = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mul_a       <= '0;
            mul_b       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_cnt     <= '0;
            max_err     <= '0;
            worst_a     <= '0;
            worst_b     <= '0;
`ifdef MUL_SWEEP_SUM_EN
            sum_abs_err <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    // abort is a no-op here; only start leaves these states
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        mul_a       <= '0;
                        mul_b       <= '0;
                        err_cnt     <= '0;
                        max_err     <= '0;
                        worst_a     <= '0;
                        worst_b     <= '0;
`ifdef MUL_SWEEP_SUM_EN
                        sum_abs_err <= '0;
`endif
                    end
                end
                RUN: begin
                    if (abort) begin
                        // statistics and operands stay frozen at the aborted point
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (diff != '0)
                            err_cnt <= err_cnt + ONE_CNT;
                        if (diff > max_err) begin
                            max_err <= diff;
                            worst_a <= mul_a;
                            worst_b <= mul_b;
                        end
`ifdef MUL_SWEEP_SUM_EN
                        sum_abs_err <= sum_abs_err + {{(2*W){1'b0}}, diff};
`endif
                        if (last_pair) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            mul_b <= mul_b + ONE_OP;
                            if (mul_b == {W{1'b1}})
                                mul_a <= mul_a + ONE_OP;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sweep_ctrl.sv
// Directed bench for mul_sweep_ctrl at W=6 (4096 pairs per sweep) with a mode-selectable multiplier stub.
module tb_mul_sweep_ctrl;

    localparam int W      = 6;
    localparam int NPAIRS = 4096;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_r;
    logic             busy;
    logic             done;
    logic [2*W:0]     err_cnt;
    logic [2*W-1:0]   max_err;
    logic [W-1:0]     worst_a;
    logic [W-1:0]     worst_b;
    logic [4*W-1:0]   sum_abs_err;

    logic [1:0]       mode;
    logic [2*W-1:0]   prod;
    int               n_cmp;
    int               n_err;

    mul_sweep_ctrl #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
        .busy(busy), .done(done), .err_cnt(err_cnt), .max_err(max_err),
        .worst_a(worst_a), .worst_b(worst_b), .sum_abs_err(sum_abs_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: exact, mode 1: LSB cleared (under-estimate), mode 2: product + b (over-estimate)
    always_comb begin
        prod  = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
        mul_r = prod;
        case (mode)
            2'd1:    mul_r = prod & ~{{(2*W-1){1'b0}}, 1'b1};
            2'd2:    mul_r = prod + {{W{1'b0}}, mul_b};
            default: mul_r = prod;
        endcase
    end

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input bit mid_start, output int cycles);
        cycles = 0;
        while (!done && cycles < 3*NPAIRS) begin
            @(negedge clk);
            cycles++;
            start = (mid_start && cycles == 1000);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0d want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0d want 0", done); end
        n_cmp++; if ({mul_a, mul_b} !== '0) begin n_err++; $display("FAIL reset_ops: got %0d,%0d want 0,0", mul_a, mul_b); end
        n_cmp++; if (err_cnt !== '0 || max_err !== '0) begin n_err++; $display("FAIL reset_stats: got %0d,%0d want 0,0", err_cnt, max_err); end
        n_cmp++; if ({worst_a, worst_b} !== '0 || sum_abs_err !== '0) begin n_err++; $display("FAIL reset_worst_sum: got %0d,%0d,%0d want 0", worst_a, worst_b, sum_abs_err); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %0d want 0", busy); end
    endtask

    task automatic test_exact_sweep();
        int cyc;
        mode = 2'd0;
        start_pulse();
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL exact_enter: busy=%0d done=%0d want 1,0", busy, done); end
        wait_done(1'b0, cyc);
        n_cmp++; if (cyc !== NPAIRS) begin n_err++; $display("FAIL exact_cycles: got %0d want %0d", cyc, NPAIRS); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL exact_flags: busy=%0d done=%0d want 0,1", busy, done); end
        n_cmp++; if (mul_a !== 6'd63 || mul_b !== 6'd63) begin n_err++; $display("FAIL exact_hold: got %0d,%0d want 63,63", mul_a, mul_b); end
        n_cmp++; if (err_cnt !== 13'd0 || max_err !== 12'd0) begin n_err++; $display("FAIL exact_stats: got %0d,%0d want 0,0", err_cnt, max_err); end
        n_cmp++; if (sum_abs_err !== 24'd0) begin n_err++; $display("FAIL exact_sum: got %0d want 0", sum_abs_err); end
        repeat (5) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || mul_a !== 6'd63) begin n_err++; $display("FAIL exact_done_level: done=%0d a=%0d want 1,63", done, mul_a); end
    endtask

    task automatic check_lsb_results(input string tag);
        logic [4*W-1:0] exp_sum;
`ifdef MUL_SWEEP_SUM_EN
        exp_sum = 24'd1024;
`else
        exp_sum = 24'd0;
`endif
        n_cmp++; if (err_cnt !== 13'd1024) begin n_err++; $display("FAIL %s_err_cnt: got %0d want 1024", tag, err_cnt); end
        n_cmp++; if (max_err !== 12'd1) begin n_err++; $display("FAIL %s_max_err: got %0d want 1", tag, max_err); end
        n_cmp++; if (worst_a !== 6'd1 || worst_b !== 6'd1) begin n_err++; $display("FAIL %s_worst: got %0d,%0d want 1,1", tag, worst_a, worst_b); end
        n_cmp++; if (sum_abs_err !== exp_sum) begin n_err++; $display("FAIL %s_sum: got %0d want %0d", tag, sum_abs_err, exp_sum); end
    endtask

    task automatic test_lsb_sweep();
        int cyc;
        mode = 2'd1;
        start_pulse();
        wait_done(1'b0, cyc);
        n_cmp++; if (cyc !== NPAIRS) begin n_err++; $display("FAIL lsb_cycles: got %0d want %0d", cyc, NPAIRS); end
        check_lsb_results("lsb");
    endtask

    task automatic test_restart_in_done();
        int cyc;
        start_pulse();
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL restart_flags: busy=%0d done=%0d want 1,0", busy, done); end
        n_cmp++; if (mul_a !== 6'd0 || mul_b !== 6'd0) begin n_err++; $display("FAIL restart_ops: got %0d,%0d want 0,0", mul_a, mul_b); end
        n_cmp++; if (err_cnt !== '0 || max_err !== '0 || {worst_a, worst_b} !== '0 || sum_abs_err !== '0) begin
            n_err++; $display("FAIL restart_clear: got %0d,%0d,%0d,%0d,%0d want 0", err_cnt, max_err, worst_a, worst_b, sum_abs_err);
        end
        wait_done(1'b0, cyc);
        n_cmp++; if (cyc !== NPAIRS) begin n_err++; $display("FAIL restart_cycles: got %0d want %0d", cyc, NPAIRS); end
        check_lsb_results("restart");
    endtask

    task automatic test_start_ignored();
        int cyc;
        logic [4*W-1:0] exp_sum;
`ifdef MUL_SWEEP_SUM_EN
        exp_sum = 24'd129024;
`else
        exp_sum = 24'd0;
`endif
        mode = 2'd2;
        start_pulse();
        wait_done(1'b1, cyc);
        n_cmp++; if (cyc !== NPAIRS) begin n_err++; $display("FAIL ignore_cycles: got %0d want %0d", cyc, NPAIRS); end
        n_cmp++; if (err_cnt !== 13'd4032) begin n_err++; $display("FAIL ignore_err_cnt: got %0d want 4032", err_cnt); end
        n_cmp++; if (max_err !== 12'd63) begin n_err++; $display("FAIL ignore_max_err: got %0d want 63", max_err); end
        n_cmp++; if (worst_a !== 6'd0 || worst_b !== 6'd63) begin n_err++; $display("FAIL ignore_worst: got %0d,%0d want 0,63", worst_a, worst_b); end
        n_cmp++; if (sum_abs_err !== exp_sum) begin n_err++; $display("FAIL ignore_sum: got %0d want %0d", sum_abs_err, exp_sum); end
    endtask

    task automatic test_abort();
        logic [4*W-1:0] exp_sum;
`ifdef MUL_SWEEP_SUM_EN
        exp_sum = 24'd2646;
`else
        exp_sum = 24'd0;
`endif
        mode = 2'd2;
        start_pulse();
        repeat (100) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL abort_flags: busy=%0d done=%0d want 0,0", busy, done); end
        n_cmp++; if (mul_a !== 6'd1 || mul_b !== 6'd36) begin n_err++; $display("FAIL abort_ops: got %0d,%0d want 1,36", mul_a, mul_b); end
        n_cmp++; if (err_cnt !== 13'd98 || max_err !== 12'd63) begin n_err++; $display("FAIL abort_stats: got %0d,%0d want 98,63", err_cnt, max_err); end
        n_cmp++; if (worst_a !== 6'd0 || worst_b !== 6'd63) begin n_err++; $display("FAIL abort_worst: got %0d,%0d want 0,63", worst_a, worst_b); end
        n_cmp++; if (sum_abs_err !== exp_sum) begin n_err++; $display("FAIL abort_sum: got %0d want %0d", sum_abs_err, exp_sum); end
        abort = 1'b1;
        repeat (20) @(negedge clk);
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || mul_b !== 6'd36 || err_cnt !== 13'd98) begin
            n_err++; $display("FAIL abort_frozen: busy=%0d b=%0d err=%0d want 0,36,98", busy, mul_b, err_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        mode = 2'd2;
        start_pulse();
        repeat (500) @(negedge clk);
        n_cmp++; if (err_cnt !== 13'd492) begin n_err++; $display("FAIL prereset_err_cnt: got %0d want 492", err_cnt); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin
            n_err++; $display("FAIL async_reset_ctrl: busy=%0d done=%0d a=%0d b=%0d want 0", busy, done, mul_a, mul_b);
        end
        n_cmp++; if (err_cnt !== '0 || max_err !== '0 || {worst_a, worst_b} !== '0 || sum_abs_err !== '0) begin
            n_err++; $display("FAIL async_reset_stats: got %0d,%0d,%0d,%0d,%0d want 0", err_cnt, max_err, worst_a, worst_b, sum_abs_err);
        end
        @(negedge clk); rst_n = 1'b1;
        start_pulse();
        n_cmp++; if (busy !== 1'b1 || mul_a !== 6'd0 || mul_b !== 6'd0) begin n_err++; $display("FAIL resweep_enter: busy=%0d a=%0d b=%0d want 1,0,0", busy, mul_a, mul_b); end
        repeat (10) @(negedge clk);
        n_cmp++; if (mul_b !== 6'd10 || err_cnt !== 13'd9) begin n_err++; $display("FAIL resweep_progress: b=%0d err=%0d want 10,9", mul_b, err_cnt); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode  = 2'd0;
        test_reset();
        test_exact_sweep();
        test_lsb_sweep();
        test_restart_in_done();
        test_start_ignored();
        test_abort();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
